// File: rtl/dcache_ctrl_pkg.sv
// Shared sizes and FSM state encoding for the blocking write-back data cache.
package dcache_ctrl_pkg;

    localparam int INDEX_SIZE    = 7;
    localparam int WORD_OFF_SIZE = 3;
    localparam int TAG_SIZE      = 32 - INDEX_SIZE - WORD_OFF_SIZE - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        RD_REQ,
        RD_WAIT,
        FILL
    } state_e;

endpackage

// File: rtl/dcache_ctrl_merge.sv
// Byte-merges one 32-bit store word into a cache line under a byte strobe.
module dcache_merge #(
    parameter int WORD_OFF_SIZE_D = 3
) (
    input  logic [(32<<WORD_OFF_SIZE_D)-1:0] line_i,
    input  logic [WORD_OFF_SIZE_D-1:0]       woff_i,
    input  logic [31:0]                      wdata_i,
    input  logic [3:0]                       wstrb_i,
    output logic [(32<<WORD_OFF_SIZE_D)-1:0] line_o
);

    localparam int NW = 1 << WORD_OFF_SIZE_D;

    always_comb begin
        line_o = line_i;
        for (int w = 0; w < NW; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (woff_i == WORD_OFF_SIZE_D'(w) && wstrb_i[b]) begin
                    line_o[w*32+b*8 +: 8] = wdata_i[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking write-back data cache controller: one request in flight,
// dirty victim written back before the refill fetch.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int INDEX_SIZE_D    = INDEX_SIZE,
    parameter int WORD_OFF_SIZE_D = WORD_OFF_SIZE,
    parameter int TAG_SIZE_D      = TAG_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic                              req_wr,
    input  logic [31:0]                       req_addr,
    input  logic [31:0]                       req_wdata,
    input  logic [3:0]                        req_wstrb,
    output logic                              req_ready,
    output logic                              resp_valid,
    output logic [31:0]                       resp_rdata,
    output logic                              mem_rd_req,
    output logic [31:0]                       mem_rd_addr,
    input  logic                              mem_rd_ready,
    input  logic                              mem_rd_valid,
    input  logic [(32<<WORD_OFF_SIZE_D)-1:0]  mem_rd_data,
    output logic                              mem_wr_req,
    output logic [31:0]                       mem_wr_addr,
    output logic [(32<<WORD_OFF_SIZE_D)-1:0]  mem_wr_data,
    input  logic                              mem_wr_ready,
    output logic                              ram_resetn,
    output logic                              ram_wen,
    output logic                              ram_wen_dv,
    output logic [INDEX_SIZE_D-1:0]           ram_a,
    output logic [INDEX_SIZE_D-1:0]           ram_dpra,
    output logic [TAG_SIZE_D-1:0]             ram_d,
    input  logic [TAG_SIZE_D-1:0]             ram_dpo,
    output logic [(32<<WORD_OFF_SIZE_D)-1:0]  ram_dina,
    input  logic [(32<<WORD_OFF_SIZE_D)-1:0]  ram_douta,
    output logic                              ram_w_valid,
    output logic                              ram_w_dirty,
    input  logic                              ram_cache_valid,
    input  logic                              ram_cache_dirty
);

    localparam int LW  = 32 << WORD_OFF_SIZE_D;
    localparam int LOW = WORD_OFF_SIZE_D + 2;

    state_e state_q, state_d;

    logic [TAG_SIZE_D-1:0]      tag_q;
    logic [TAG_SIZE_D-1:0]      vtag_q;
    logic [INDEX_SIZE_D-1:0]    idx_q;
    logic [WORD_OFF_SIZE_D-1:0] woff_q;
    logic                       wr_q;
    logic [31:0]                wdata_q;
    logic [3:0]                 wstrb_q;
    logic [LW-1:0]              victim_q;
    logic [LW-1:0]              fill_q;

    logic [TAG_SIZE_D-1:0]      req_tag;
    logic [INDEX_SIZE_D-1:0]    req_idx;
    logic [WORD_OFF_SIZE_D-1:0] req_woff;
    logic [1:0]                 unused_byte;

    logic                       hit;
    logic                       accept;
    logic [LW-1:0]              merge_in;
    logic [LW-1:0]              merged;

    assign {req_tag, req_idx, req_woff, unused_byte} = req_addr;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_ready & req_valid;
    assign hit        = ram_cache_valid & (ram_dpo == tag_q);
    assign ram_resetn = ~reset;

    // Index comes straight from the request in IDLE so the data RAM
    // read lands in LOOKUP; afterwards the latched index is held.
    assign ram_a    = req_ready ? req_idx : idx_q;
    assign ram_dpra = req_ready ? req_idx : idx_q;
    assign ram_d    = tag_q;

    assign mem_wr_req  = (state_q == WB);
    assign mem_wr_addr = {vtag_q, idx_q, {LOW{1'b0}}};
    assign mem_wr_data = victim_q;
    assign mem_rd_req  = (state_q == RD_REQ);
    assign mem_rd_addr = {tag_q, idx_q, {LOW{1'b0}}};

    assign merge_in = (state_q == FILL) ? fill_q : ram_douta;

    dcache_merge #(
        .WORD_OFF_SIZE_D(WORD_OFF_SIZE_D)
    ) u_merge (
        .line_i (merge_in),
        .woff_i (woff_q),
        .wdata_i(wdata_q),
        .wstrb_i(wstrb_q),
        .line_o (merged)
    );

    always_comb begin
        state_d     = state_q;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        ram_wen     = 1'b0;
        ram_wen_dv  = 1'b0;
        ram_w_valid = 1'b0;
        ram_w_dirty = 1'b0;
        ram_dina    = merged;
        unique case (state_q)
            IDLE: begin
                if (req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                    if (wr_q) begin
                        ram_wen     = 1'b1;
                        ram_wen_dv  = 1'b1;
                        ram_w_valid = 1'b1;
                        ram_w_dirty = 1'b1;
                    end else begin
                        resp_rdata = ram_douta[{woff_q, 5'b0} +: 32];
                    end
                end else if (ram_cache_valid & ram_cache_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = RD_REQ;
                end
            end
            WB: begin
                if (mem_wr_ready) state_d = RD_REQ;
            end
            RD_REQ: begin
                if (mem_rd_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rd_valid) state_d = FILL;
            end
            FILL: begin
                ram_wen     = 1'b1;
                ram_wen_dv  = 1'b1;
                ram_w_valid = 1'b1;
                ram_w_dirty = wr_q;
                ram_dina    = wr_q ? merged : fill_q;
                resp_valid  = 1'b1;
                resp_rdata  = fill_q[{woff_q, 5'b0} +: 32];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            vtag_q   <= '0;
            idx_q    <= '0;
            woff_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            victim_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q   <= req_tag;
                idx_q   <= req_idx;
                woff_q  <= req_woff;
                wr_q    <= req_wr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (state_q == LOOKUP && !hit) begin
                victim_q <= ram_douta;
                vtag_q   <= ram_dpo;
            end
            if (state_q == RD_WAIT && mem_rd_valid) begin
                fill_q <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with behavioural tag/data RAM and memory.
module tb_dcache_ctrl;

    localparam int LW = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid, req_wr;
    logic [31:0]     req_addr, req_wdata;
    logic [3:0]      req_wstrb;
    logic            req_ready, resp_valid;
    logic [31:0]     resp_rdata;
    logic            mem_rd_req, mem_rd_ready, mem_rd_valid;
    logic [31:0]     mem_rd_addr;
    logic [LW-1:0]   mem_rd_data;
    logic            mem_wr_req, mem_wr_ready;
    logic [31:0]     mem_wr_addr;
    logic [LW-1:0]   mem_wr_data;
    logic            ram_resetn, ram_wen, ram_wen_dv;
    logic [6:0]      ram_a, ram_dpra;
    logic [19:0]     ram_d, ram_dpo;
    logic [LW-1:0]   ram_dina, ram_douta;
    logic            ram_w_valid, ram_w_dirty;
    logic            ram_cache_valid, ram_cache_dirty;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ready(mem_rd_ready), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .ram_resetn(ram_resetn), .ram_wen(ram_wen), .ram_wen_dv(ram_wen_dv),
        .ram_a(ram_a), .ram_dpra(ram_dpra), .ram_d(ram_d), .ram_dpo(ram_dpo),
        .ram_dina(ram_dina), .ram_douta(ram_douta),
        .ram_w_valid(ram_w_valid), .ram_w_dirty(ram_w_dirty),
        .ram_cache_valid(ram_cache_valid), .ram_cache_dirty(ram_cache_dirty)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Tag/data/valid/dirty RAM
    logic [19:0]   tagm [128];
    logic [LW-1:0] datm [128];
    logic          vm   [128];
    logic          dm   [128];

    initial begin
        for (int i = 0; i < 128; i++) begin
            tagm[i] = '0; datm[i] = '0; vm[i] = 1'b0; dm[i] = 1'b0;
        end
    end

    assign ram_dpo         = tagm[ram_dpra];
    assign ram_cache_valid = vm[ram_dpra];
    assign ram_cache_dirty = dm[ram_dpra];

    always @(posedge clk) begin
        ram_douta <= datm[ram_a];
        if (ram_wen) begin
            tagm[ram_a] <= ram_d;
            datm[ram_a] <= ram_dina;
        end
        if (!ram_resetn) begin
            for (int i = 0; i < 128; i++) begin
                vm[i] <= 1'b0; dm[i] <= 1'b0;
            end
        end else if (ram_wen_dv) begin
            vm[ram_a] <= ram_w_valid;
            dm[ram_a] <= ram_w_dirty;
        end
    end

    // Backing memory and reference model
    logic [LW-1:0] mem  [logic [31:0]];
    logic [31:0]   refm [logic [31:0]];

    function automatic logic [31:0] patw(input logic [31:0] a);
        logic [7:0] w;
        w = {5'b0, a[4:2]} + 8'd1;
        return {16'hCAFE ^ {12'h0, a[19:16]}, a[15:8] ^ 8'h10, w};
    endfunction

    function automatic logic [LW-1:0] memline(input logic [31:0] la);
        logic [LW-1:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = patw(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0]   k;
        logic [LW-1:0] l;
        k = a & ~32'h3;
        if (refm.exists(k)) return refm[k];
        l = memline(a & ~32'h1F);
        return l[{a[4:2], 5'b0} +: 32];
    endfunction

    function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        logic [31:0] v;
        v = ref_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        refm[a & ~32'h3] = v;
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1'b1, 1'b0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (!e.wr) chk("rdata", resp_rdata, e.data);
            end
        end
    end

    // Memory responder
    int unsigned   wr_delay = 0;
    int unsigned   rd_lat = 1;
    logic          rd_block = 1'b0;
    logic          force_valid = 1'b0;
    logic          pend = 1'b0;
    logic [31:0]   rd_log[$];
    logic [31:0]   wb_log[$];

    initial begin
        int unsigned wcnt = 0;
        int unsigned cnt = 0;
        logic [31:0] paddr = '0;
        logic [31:0] waddr = '0;
        mem_rd_ready = 1'b0; mem_rd_valid = 1'b0;
        mem_wr_ready = 1'b0; mem_rd_data = '0;
        forever begin
            @(negedge clk);
            mem_rd_ready = 1'b0; mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
            if (force_valid) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = {8{32'hBAD0_BAD0}};
            end
            if (reset) begin
                pend = 1'b0; wcnt = 0;
                continue;
            end
            if (wcnt > 0 || mem_wr_req) begin
                if (wcnt > 0) begin
                    chk("wb_req_hold", mem_wr_req, 1'b1);
                    chk("wb_addr_hold", mem_wr_addr, waddr);
                    chk("wb_ready_low", req_ready, 1'b0);
                end else begin
                    waddr = mem_wr_addr;
                end
                if (wcnt == wr_delay) begin
                    mem_wr_ready = 1'b1;
                    mem[mem_wr_addr] = mem_wr_data;
                    wb_log.push_back(mem_wr_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            if (mem_rd_req && !pend) begin
                mem_rd_ready = 1'b1;
                pend = 1'b1;
                paddr = mem_rd_addr;
                cnt = rd_lat;
                rd_log.push_back(paddr);
            end else if (pend && !mem_rd_req) begin
                if (cnt == 0) begin
                    if (!rd_block) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_data  = memline(paddr);
                        pend = 1'b0;
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        sb_t e;
        int  n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        e.wr   = wr;
        e.data = ref_rd(a);
        if (wr) ref_wr(a, d, s);
        sb.push_back(e);
        req_valid = 1'b1; req_wr = wr; req_addr = a;
        req_wdata = d; req_wstrb = s;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd;
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp", resp_valid, 1'b0);
        chk("rst_ramresetn", ram_resetn, 1'b0);
        chk("rst_rdreq", mem_rd_req, 1'b0);
        chk("rst_wrreq", mem_wr_req, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // cold read miss
        issue(1'b0, 32'h0000_1040, 32'h0, 4'h0);
        wait_idle();
        chk("cold_rd_addr", rd_log[0], 32'h0000_1040);
        chk("cold_no_wb", 32'(wb_log.size()), 32'd0);

        // hit: response one cycle after accept
        nrd = rd_log.size();
        issue(1'b0, 32'h0000_1044, 32'h0, 4'h0);
        @(negedge clk);
        chk("hit_latency", resp_valid, 1'b1);
        chk("hit_no_rdreq", mem_rd_req, 1'b0);
        wait_idle();
        chk("hit_no_fetch", 32'(rd_log.size()), 32'(nrd));

        // write hit
        issue(1'b1, 32'h0000_1040, 32'h1122_3344, 4'b0101);
        @(negedge clk);
        chk("wh_wen", ram_wen, 1'b1);
        chk("wh_wen_dv", ram_wen_dv, 1'b1);
        chk("wh_dirty", ram_w_dirty, 1'b1);
        wait_idle();
        issue(1'b0, 32'h0000_1040, 32'h0, 4'h0);
        wait_idle();

        // dirty eviction with slow writeback; bogus requests while busy
        wr_delay = 5;
        nrd = rd_log.size();
        issue(1'b0, 32'h0008_1040, 32'h0, 4'h0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                req_valid = 1'b0;
                break;
            end
            req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0030_0000;
        end
        req_valid = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);
        wr_delay = 0;
        chk("wb_count", 32'(wb_log.size()), 32'd1);
        chk("wb_addr", wb_log[0], 32'h0000_1040);
        chk("wb_word0", mem[32'h0000_1040][31:0], 32'hCA22_0044);
        chk("ev_rd_count", 32'(rd_log.size()), 32'(nrd + 1));
        chk("ev_rd_addr", rd_log[$], 32'h0008_1040);

        // store miss then reads of that line; refetch of evicted line
        issue(1'b1, 32'h0010_2064, 32'hDEAD_BEEF, 4'hF);
        wait_idle();
        issue(1'b0, 32'h0010_2064, 32'h0, 4'h0);
        issue(1'b0, 32'h0010_2060, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_1040, 32'h0, 4'h0);
        wait_idle();

        // mixed traffic over a few conflicting tags
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'h0000_1000 | (32'($urandom_range(0, 3)) << 16)
              | (32'($urandom_range(4, 5)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            rd_lat   = $urandom_range(0, 3);
            wr_delay = $urandom_range(0, 2);
            issue(1'($urandom_range(0, 1)), a, $urandom,
                  4'($urandom_range(1, 15)));
            wait_idle();
        end
        wr_delay = 0; rd_lat = 1;

        // reset while waiting for fill data
        rd_block = 1'b1;
        issue(1'b0, 32'h0020_2080, 32'h0, 4'h0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pend && !mem_rd_req) break;
        end
        chk("rw_reached", pend && !mem_rd_req, 1'b1);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_resp", resp_valid, 1'b0);
        chk("mid_rdata", resp_rdata, 32'h0);
        chk("mid_rdreq", mem_rd_req, 1'b0);
        chk("mid_wrreq", mem_wr_req, 1'b0);
        chk("mid_wen", ram_wen, 1'b0);
        chk("mid_wen_dv", ram_wen_dv, 1'b0);
        chk("mid_ramresetn", ram_resetn, 1'b0);
        reset = 1'b0;
        rd_block = 1'b0;
        refm.delete();
        @(negedge clk);
        chk("post_ready", req_ready, 1'b1);
        chk("post_ramresetn", ram_resetn, 1'b1);
        force_valid = 1'b1;
        repeat (2) @(negedge clk);
        force_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_valid_ready", req_ready, 1'b1);
        chk("late_valid_resp", resp_valid, 1'b0);

        issue(1'b0, 32'h0000_1040, 32'h0, 4'h0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL take parameter INDEX_SIZE_D, default 7, meaning line-index width (128 lines).
REQ-002 The block SHALL take parameter WORD_OFF_SIZE_D, default 3, meaning word-offset width (8 words, 256-bit line).
REQ-003 The block SHALL take parameter TAG_SIZE_D, default 20, meaning tag width (32 - INDEX - WORD_OFF - 2).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports, with clock and reset first (LW = 32*2^WORD_OFF_SIZE_D):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  CPU request
- req_wr  in  1  1 = store
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_wstrb  in  4  byte enables
- req_ready  out  1  request accepted when req_valid & req_ready
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  32  load data, valid with resp_valid
- mem_rd_req  out  1  line fetch request
- mem_rd_addr  out  32  line-aligned fetch address
- mem_rd_ready  in  1  fetch request accepted
- mem_rd_valid  in  1  fetch data returned
- mem_rd_data  in  LW  fetched line
- mem_wr_req  out  1  victim writeback request
- mem_wr_addr  out  32  line-aligned victim address
- mem_wr_data  out  LW  victim line
- mem_wr_ready  in  1  writeback accepted
- ram_resetn  out  1  equals ~reset, clears RAM valid/dirty
- ram_wen  out  1  tag and data write enable
- ram_wen_dv  out  1  valid/dirty write enable
- ram_a  out  INDEX  write and data-read index
- ram_dpra  out  INDEX  tag and valid/dirty read index
- ram_d  out  TAG  tag to write
- ram_dpo  in  TAG  tag read, combinational on ram_dpra
- ram_dina  out  LW  line to write
- ram_douta  in  LW  data read, one cycle after ram_a
- ram_w_valid, ram_w_dirty  out  1 each  valid/dirty values to write
- ram_cache_valid, ram_cache_dirty  in  1 each  valid/dirty read, combinational on ram_dpra

Function
REQ-006 The FSM SHALL use the states IDLE, LOOKUP, WB, RD_REQ, RD_WAIT and FILL.
REQ-007 req_ready SHALL equal (state==IDLE).
- On accept, the block latches addr, wr, wdata and wstrb, drives ram_a = ram_dpra = addr index, and moves to LOOKUP.
REQ-008 While outside IDLE, ram_a and ram_dpra SHALL hold the latched index.
REQ-009 LOOKUP SHALL compute hit = ram_cache_valid & (ram_dpo == latched tag).
REQ-010 Read hit in LOOKUP:
- resp_valid = 1.
- resp_rdata = word of ram_douta selected by addr[WORD_OFF+1:2].
- Next state IDLE; load latency is 1 cycle after accept.
REQ-011 Write hit in LOOKUP:
- Write back ram_douta with the selected word byte-merged under wstrb.
- ram_wen = ram_wen_dv = 1, ram_d = tag, w_valid = 1, w_dirty = 1.
- resp_valid = 1; next state IDLE.
REQ-012 Miss in LOOKUP:
- Latch victim line = ram_douta and victim tag = ram_dpo.
- If ram_cache_valid & ram_cache_dirty, go to WB; otherwise go to RD_REQ.
REQ-013 WB SHALL hold mem_wr_req = 1, mem_wr_addr = {victim tag, index, 0s} and mem_wr_data = victim line until mem_wr_ready, then go to RD_REQ.
REQ-014 RD_REQ SHALL hold mem_rd_req = 1 with mem_rd_addr = {tag, index, 0s} until mem_rd_ready, then go to RD_WAIT.
- If mem_rd_ready is high on the first cycle, the handshake completes in that cycle.
REQ-015 RD_WAIT SHALL latch mem_rd_data on mem_rd_valid and go to FILL.
REQ-016 FILL SHALL, for one cycle:
- Drive ram_wen = ram_wen_dv = 1, ram_d = tag, w_valid = 1, w_dirty = req_wr.
- Drive ram_dina = fetched line, merged with the store if req_wr.
- Pulse resp_valid with the requested word taken from the fetched line.
- Go to IDLE.
REQ-017 ram_wen and ram_wen_dv SHALL be asserted only in LOOKUP write-hit and FILL; mem_wr_req only in WB; mem_rd_req only in RD_REQ.
REQ-018 A request presented while req_ready = 0 SHALL be ignored and SHALL NOT be latched.

Reset
REQ-019 Reset SHALL force state to IDLE and drive these values on the next edge, including mid-operation, abandoning any outstanding memory handshake:
- resp_valid, mem_rd_req, mem_wr_req, ram_wen, ram_wen_dv = 0.
- resp_rdata = 0.
- All latches = 0.
REQ-020 ram_resetn SHALL be low for every cycle reset is high.

Structure
REQ-021 Cache_define.v SHALL hold INDEX/TAG/WORD_OFF sizes and the state encodings.
REQ-022 Byte-merge of a word into a line SHALL be a sub-module, dcache_merge.

Verification
REQ-023 Cold read of 0x0000_1040 after reset leads to RD_REQ with mem_rd_addr = 0x0000_1040; returning a line with word0 = 0xCAFE_0001 gives resp_rdata = 0xCAFE_0001 in FILL.
REQ-024 A repeat read of 0x0000_1044 is a hit: resp_valid is asserted 1 cycle after accept, with no mem request.
REQ-025 Write 0x1122_3344 with wstrb = 4'b0101 to 0x0000_1040 on a hit, then read, returns 0xCA22_0044 with w_dirty = 1.
REQ-026 Read of 0x0008_1040 (same index, dirty) gives mem_wr_addr = 0x0000_1040 with the merged line, then mem_rd_addr = 0x0008_1040.
REQ-027 Reset asserted in RD_WAIT gives all outputs zeroed next cycle and req_ready = 1 after reset drops; a later mem_rd_valid is ignored.
REQ-028 mem_wr_ready held low for 5 cycles keeps mem_wr_req stable and req_ready = 0 throughout.
